muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand, HI and LO width (even, at least 8).
REQ-002 SHALL have parameter CONTROL_LENGTH, default 4: width of the ALU control code.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: operation request, qualified by control.
REQ-006 SHALL have port control, input, CONTROL_LENGTH bits: ALU control code; 10 = multiply, 11 = divide.
REQ-007 SHALL have port is_unsigned, input, 1 bit: 1 selects the unsigned variant (multu/divu).
REQ-008 SHALL have ports a and b, input, DATA_WIDTH bits each: multiplicand/dividend (a) and multiplier/divisor (b).
REQ-009 SHALL have ports hi_we and lo_we, input, 1 bit each: mthi/mtlo write strobes.
REQ-010 SHALL have port wdata, input, DATA_WIDTH bits: mthi/mtlo write data.
REQ-011 SHALL have ports hi and lo, output, DATA_WIDTH bits each: architectural HI and LO registers.
REQ-012 SHALL have port busy, output, 1 bit: an operation is iterating.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse; results are valid in hi/lo.
REQ-014 SHALL have port div_by_zero, output, 1 bit: pulses together with done when a divide had b == 0.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and FIN.
REQ-016 SHALL accept start in IDLE or FIN only when control is 10 or 11; start with any other code SHALL be ignored.
REQ-017 SHALL, on accept, latch a, b, control and is_unsigned, and enter RUN; busy=1 throughout RUN.
REQ-018 SHALL, in RUN, perform one radix-2 iteration per cycle (shift-add multiply, restoring divide on operand magnitudes), with exactly DATA_WIDTH RUN cycles.
REQ-019 SHALL, on the edge leaving RUN, write hi/lo and enter FIN; in FIN, done=1, busy=0, and the new hi/lo are visible.
REQ-020 SHALL therefore assert done exactly DATA_WIDTH+1 cycles after the accepting edge; FIN SHALL last one cycle, then go to IDLE, or to RUN if start is accepted in FIN (back-to-back).
REQ-021 Multiply SHALL produce the full 2*DATA_WIDTH-bit product: {hi,lo}; signed mode uses two's-complement operands.
REQ-022 Divide SHALL produce lo=quotient and hi=remainder; in signed mode the quotient truncates toward zero and the remainder takes the sign of a.
REQ-023 Signed divide of the most negative value by -1 SHALL give lo=most negative value, hi=0, with no flag.
REQ-024 Divide by zero SHALL still take full latency and give hi=a, lo=all ones, with div_by_zero=1 during FIN.
REQ-025 start SHALL be ignored while busy=1; there is no abort path except reset.
REQ-026 hi_we/lo_we SHALL update hi/lo from wdata on the edge when busy=0 (including FIN, where the write takes priority over the completing result already written); the strobes SHALL be ignored while busy=1.
REQ-027 A write and an accepted start on the same edge SHALL both take effect; the operation result later overwrites hi/lo.

Reset
REQ-028 SHALL, when rst_n=0, immediately force state=IDLE, hi=0, lo=0, busy=0, done=0 and div_by_zero=0, including mid-operation; the aborted operation SHALL produce no done pulse.
REQ-029 SHALL accept start on the first rising edge after rst_n is released.

Structure
REQ-030 SHALL place control codes ALU_MULT=10 and ALU_DIV=11, together with the FSM state typedef, in the shared mips package used by the ALU control logic.
REQ-031 SHALL be a single module with no sub-module; the datapath is one 2*DATA_WIDTH+1-bit shift register plus a log2(DATA_WIDTH+1)-bit iteration counter.

Verification (DATA_WIDTH=32)
REQ-032 Signed mult a=0xFFFFFFFD, b=7: done exactly 33 cycles after the start edge, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 multu a=b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001; the same operands signed give hi=0, lo=1.
REQ-034 Signed div a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=100, b=0: hi=0x64, lo=0xFFFFFFFF, div_by_zero=1 with done.
REQ-035 Assert rst_n=0 at RUN cycle 10: outputs zero immediately, no done pulse; a new mult after release completes normally.
REQ-036 Back-to-back: start in FIN begins a new RUN the next cycle; start with control=5 is ignored; hi_we during busy is ignored; hi_we together with start in IDLE shows wdata on hi until FIN.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU control codes used by the ALU control
// decoder and the multiply/divide unit, plus the mul/div FSM state type.
package mips_pkg;

    localparam int ALU_MULT = 10;
    localparam int ALU_DIV  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add and divide is restoring, both on operand magnitudes;
// signs are applied when the result is written. One iteration per cycle,
// DATA_WIDTH iterations per operation.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int CONTROL_LENGTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CONTROL_LENGTH-1:0] control,
    input  logic                      is_unsigned,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    input  logic                      hi_we,
    input  logic                      lo_we,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     hi,
    output logic [DATA_WIDTH-1:0]     lo,
    output logic                      busy,
    output logic                      done,
    output logic                      div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    muldiv_state_t   state_q, state_d;
    logic [2*W:0]    p_q, p_step, mul_step, div_step;
    logic [W-1:0]    opnd_q, a_mag, b_mag;
    logic            is_div_q, neg_q_q, neg_r_q, dz_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    hi_q, lo_q, res_hi, res_lo, quo, rem;
    logic [W:0]      mul_sum, rem_sh;
    logic [W+1:0]    diff;
    logic [2*W-1:0]  prod, prod_s;
    logic            req_mult, req_div, accept, last;

    assign req_mult = (control == CONTROL_LENGTH'(ALU_MULT));
    assign req_div  = (control == CONTROL_LENGTH'(ALU_DIV));
    assign accept   = start && (state_q != RUN) && (req_mult || req_div);
    assign last     = (cnt_q == CW'(W - 1));
    assign a_mag    = (!is_unsigned && a[W-1]) ? -a : a;
    assign b_mag    = (!is_unsigned && b[W-1]) ? -b : b;

    // One radix-2 step of both algorithms; the latched op selects which is kept.
    // Multiply: {carry, partial high, multiplier} shifts right, adding the
    // multiplicand when the multiplier LSB is set. Divide: {remainder,
    // dividend/quotient} shifts left, subtracting the divisor when it fits.
    always_comb begin
        mul_sum = p_q[2*W:W];
        if (p_q[0]) begin
            mul_sum = p_q[2*W:W] + {1'b0, opnd_q};
        end
        mul_step = {1'b0, mul_sum, p_q[W-1:1]};
        rem_sh   = p_q[2*W-1:W-1];
        diff     = {1'b0, rem_sh} - {2'b00, opnd_q};
        if (!diff[W+1]) begin
            div_step = {diff[W:0], p_q[W-2:0], 1'b1};
        end else begin
            div_step = {rem_sh, p_q[W-2:0], 1'b0};
        end
        p_step = is_div_q ? div_step : mul_step;
    end

    // Sign correction of the final step's value into HI/LO form.
    // A zero divisor leaves the full dividend magnitude as the remainder, so
    // re-applying the dividend sign yields hi == a without a special case.
    always_comb begin
        prod   = (2*W)'(p_step);
        prod_s = neg_q_q ? -prod : prod;
        quo    = p_step[W-1:0];
        rem    = W'(p_step[2*W:W]);
        res_hi = prod_s[2*W-1:W];
        res_lo = prod_s[W-1:0];
        if (is_div_q) begin
            res_hi = neg_r_q ? -rem : rem;
            res_lo = dz_q ? '1 : (neg_q_q ? -quo : quo);
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_d = FIN;
            end
            FIN: begin
                done        = 1'b1;
                div_by_zero = dz_q;
                state_d     = accept ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand latch on accept, then one iteration per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q      <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            p_q      <= {{(W+1){1'b0}}, (req_div ? a_mag : b_mag)};
            opnd_q   <= req_div ? b_mag : a_mag;
            is_div_q <= req_div;
            neg_q_q  <= !is_unsigned && (a[W-1] ^ b[W-1]);
            neg_r_q  <= !is_unsigned && a[W-1];
            dz_q     <= req_div && (b == '0);
            cnt_q    <= '0;
        end else if (state_q == RUN) begin
            p_q      <= p_step;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    // HI/LO: software writes when idle, results on the edge leaving RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (!busy) begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
        end else if (last) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes hand-computed results into
// a scoreboard queue; a negedge monitor checks each done pulse against it.
module tb_muldiv_unit;

    logic        clk, rst_n, start, is_unsigned, hi_we, lo_we;
    logic [3:0]  control;
    logic [31:0] a, b, wdata, hi, lo;
    logic        busy, done, div_by_zero;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    muldiv_unit #(.DATA_WIDTH(32), .CONTROL_LENGTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .control(control),
        .is_unsigned(is_unsigned), .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we),
        .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected no pending op");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.name, "_dz"}, 64'(div_by_zero), 64'(e.dz));
                check({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'd33);
            end
        end
        if (rst_n && div_by_zero && !done) begin
            n_vec++;
            n_err++;
            $display("FAIL dz_without_done: got div_by_zero=1, expected 0");
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input string name, input logic [3:0] ctrl, input logic uns,
                         input logic [31:0] ai, input logic [31:0] bi,
                         input logic [31:0] hi_e, input logic [31:0] lo_e, input logic dz_e);
        exp_t e;
        control     = ctrl;
        is_unsigned = uns;
        a           = ai;
        b           = bi;
        start       = 1'b1;
        e.name = name; e.hi = hi_e; e.lo = lo_e; e.dz = dz_e; e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; control = '0; is_unsigned = 1'b0;
        a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);

        // Start accepted on the first edge after release.
        rst_n = 1'b1;
        issue("mult_m3x7", 4'd10, 1'b0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        wait_done("mult_m3x7");
        // mtlo in FIN overrides the just-written result.
        lo_we = 1'b1; wdata = 32'h00000055;
        @(negedge clk);
        lo_we = 1'b0;
        check("fin_mtlo_lo", 64'(lo), 64'h55);
        check("fin_mtlo_hi", 64'(hi), 64'hFFFFFFFF);

        // Back-to-back: second op accepted on the FIN edge.
        issue("multu_ones", 4'd10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        wait_done("multu_ones");
        issue("mult_m1xm1", 4'd10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done("mult_m1xm1");

        issue("div_m7_2", 4'd11, 1'b0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        wait_done("div_m7_2");
        issue("divu_100_0", 4'd11, 1'b1, 32'd100, 32'd0, 32'h64, 32'hFFFFFFFF, 1'b1);
        wait_done("divu_100_0");
        issue("div_min_m1", 4'd11, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        wait_done("div_min_m1");
        issue("divu_100_7", 4'd11, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done("divu_100_7");
        issue("div_7_m2", 4'd11, 1'b0, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
        wait_done("div_7_m2");
        issue("div_m5_0", 4'd11, 1'b0, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        wait_done("div_m5_0");
        issue("mult_min_min", 4'd10, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
        wait_done("mult_min_min");
        issue("multu_shift", 4'd10, 1'b1, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0);
        wait_done("multu_shift");
        @(negedge clk);

        // Unsupported control code is ignored.
        control = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ctrl5_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("ctrl5_idle_busy", 64'(busy), 64'd0);

        // mthi while busy is dropped.
        issue("multu_3x5", 4'd10, 1'b1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        hi_we = 1'b0;
        check("busy_mthi_hi", 64'(hi), 64'h1);
        wait_done("multu_3x5");
        @(negedge clk);

        // mthi together with start in IDLE: wdata visible until FIN.
        hi_we = 1'b1; wdata = 32'hCAFEF00D;
        issue("multu_2x3", 4'd10, 1'b1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        hi_we = 1'b0;
        check("idle_mthi_hi", 64'(hi), 64'hCAFEF00D);
        repeat (20) @(negedge clk);
        check("idle_mthi_hold", 64'(hi), 64'hCAFEF00D);
        wait_done("multu_2x3");
        @(negedge clk);

        // Reset mid-operation: immediate clear, no done from the aborted op.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        control = 4'd10; is_unsigned = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue("mult_m3x5", 4'd10, 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        wait_done("mult_m3x5");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
